// File: rtl/cop0_exception_sequencer.sv
// Multi-cycle CP0 exception/ERET sequencer: read-modify-write of EPC, Cause, BadVAddr, Status.
// Optional: define COP0_EXC_VECTOR_EBASE_EN to derive the handler vector from EBase.
module cop0_exception_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        exc_has_badvaddr,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  output logic        busy,
  output logic        done,
  output logic [31:0] handler_pc,
  output logic        cop0_we,
  output logic [4:0]  cop0_write_rd,
  output logic [2:0]  cop0_write_sel,
  output logic [31:0] cop0_din,
  output logic [4:0]  cop0_read_rd,
  output logic [2:0]  cop0_read_sel,
  input  logic [31:0] cop0_rdata
);

  localparam logic [4:0]  RD_BADVADDR    = 5'd8;
  localparam logic [4:0]  RD_STATUS      = 5'd12;
  localparam logic [4:0]  RD_CAUSE       = 5'd13;
  localparam logic [4:0]  RD_EPC         = 5'd14;
  localparam logic [2:0]  SEL_0          = 3'd0;
  localparam logic [31:0] CAUSE_CLR_MASK = 32'h8000_007C;
  localparam logic [31:0] STATUS_EXL     = 32'h0000_0002;
`ifdef COP0_EXC_VECTOR_EBASE_EN
  localparam logic [4:0]  RD_EBASE       = 5'd15;
  localparam logic [2:0]  SEL_EBASE      = 3'd1;
`else
  localparam logic [31:0] DEFAULT_VECTOR = 32'h8000_0180;
`endif

  typedef enum logic [3:0] {
    IDLE,
    S_CHK,
    S_EPC,
    S_CAUSE,
    S_BADV,
    S_STAT,
    S_DONE,
    E_EPC,
    E_STAT
`ifdef COP0_EXC_VECTOR_EBASE_EN
    , S_VEC
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] handler_pc_q, handler_pc_d;
  logic        exl_q, exl_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic        has_badv_q, has_badv_d;
  logic [31:0] badv_q, badv_d;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      handler_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      handler_pc_q <= handler_pc_d;
    end
  end

  // NOTE: request payload is only consumed after IDLE has loaded it, so it needs no reset.
  always_ff @(posedge clk) begin
    exl_q      <= exl_d;
    code_q     <= code_d;
    epc_q      <= epc_d;
    bd_q       <= bd_d;
    has_badv_q <= has_badv_d;
    badv_q     <= badv_d;
  end

  // NOTE: every output of this block gets a default first so no latches are inferred.
  always_comb begin
    state_d        = state_q;
    handler_pc_d   = handler_pc_q;
    exl_d          = exl_q;
    code_d         = code_q;
    epc_d          = epc_q;
    bd_d           = bd_q;
    has_badv_d     = has_badv_q;
    badv_d         = badv_q;
    busy           = (state_q != IDLE);
    done           = (state_q == S_DONE);
    cop0_we        = 1'b0;
    cop0_write_rd  = '0;
    cop0_write_sel = '0;
    cop0_din       = '0;
    cop0_read_rd   = '0;
    cop0_read_sel  = '0;

    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          code_d     = exc_code;
          epc_d      = exc_epc;
          bd_d       = exc_bd;
          has_badv_d = exc_has_badvaddr;
          badv_d     = exc_badvaddr;
          state_d    = S_CHK;
        end else if (eret_valid) begin
          state_d = E_EPC;
        end
      end

      S_CHK: begin
        cop0_read_rd  = RD_STATUS;
        cop0_read_sel = SEL_0;
        exl_d         = cop0_rdata[1];
        state_d       = cop0_rdata[1] ? S_CAUSE : S_EPC;
      end

      S_EPC: begin
        cop0_we        = 1'b1;
        cop0_write_rd  = RD_EPC;
        cop0_write_sel = SEL_0;
        cop0_din       = bd_q ? (epc_q - 32'd4) : epc_q;
        state_d        = S_CAUSE;
      end

      S_CAUSE: begin
        // A nested exception must not disturb the BD bit of the outer one.
        cop0_read_rd   = RD_CAUSE;
        cop0_read_sel  = SEL_0;
        cop0_we        = 1'b1;
        cop0_write_rd  = RD_CAUSE;
        cop0_write_sel = SEL_0;
        cop0_din       = (cop0_rdata & ~CAUSE_CLR_MASK) | {25'd0, code_q, 2'b00};
        cop0_din[31]   = exl_q ? cop0_rdata[31] : bd_q;
        state_d        = has_badv_q ? S_BADV : S_STAT;
      end

      S_BADV: begin
        cop0_we        = 1'b1;
        cop0_write_rd  = RD_BADVADDR;
        cop0_write_sel = SEL_0;
        cop0_din       = badv_q;
        state_d        = S_STAT;
      end

      S_STAT: begin
        cop0_read_rd   = RD_STATUS;
        cop0_read_sel  = SEL_0;
        cop0_we        = 1'b1;
        cop0_write_rd  = RD_STATUS;
        cop0_write_sel = SEL_0;
        cop0_din       = cop0_rdata | STATUS_EXL;
`ifdef COP0_EXC_VECTOR_EBASE_EN
        state_d        = S_VEC;
`else
        handler_pc_d   = DEFAULT_VECTOR;
        state_d        = S_DONE;
`endif
      end

`ifdef COP0_EXC_VECTOR_EBASE_EN
      S_VEC: begin
        cop0_read_rd  = RD_EBASE;
        cop0_read_sel = SEL_EBASE;
        handler_pc_d  = {cop0_rdata[31:12], 12'h180};
        state_d       = S_DONE;
      end
`endif

      E_EPC: begin
        cop0_read_rd  = RD_EPC;
        cop0_read_sel = SEL_0;
        handler_pc_d  = cop0_rdata;
        state_d       = E_STAT;
      end

      E_STAT: begin
        cop0_read_rd   = RD_STATUS;
        cop0_read_sel  = SEL_0;
        cop0_we        = 1'b1;
        cop0_write_rd  = RD_STATUS;
        cop0_write_sel = SEL_0;
        cop0_din       = cop0_rdata & ~STATUS_EXL;
        state_d        = S_DONE;
      end

      S_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Reset in mid-sequence must not let the write in flight reach the register file.
    if (reset) begin
      done           = 1'b0;
      cop0_we        = 1'b0;
      cop0_write_rd  = '0;
      cop0_write_sel = '0;
      cop0_din       = '0;
    end
  end

  assign handler_pc = handler_pc_q;

endmodule

// File: tb/tb_cop0_exception_sequencer.sv
// Scoreboard bench for cop0_exception_sequencer: a CP0 register-file model plus queues of expected
// writes, completions and per-cycle snapshots, checked by a single negedge monitor.
module tb_cop0_exception_sequencer;

`ifdef COP0_EXC_VECTOR_EBASE_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  localparam logic [7:0] A_BADV   = {5'd8,  3'd0};
  localparam logic [7:0] A_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC    = {5'd14, 3'd0};
  localparam logic [7:0] A_EBASE  = {5'd15, 3'd1};
  localparam logic [31:0] VEC_PC  = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        exc_has_badvaddr;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;
  logic        busy;
  logic        done;
  logic [31:0] handler_pc;
  logic        cop0_we;
  logic [4:0]  cop0_write_rd;
  logic [2:0]  cop0_write_sel;
  logic [31:0] cop0_din;
  logic [4:0]  cop0_read_rd;
  logic [2:0]  cop0_read_sel;
  logic [31:0] cop0_rdata;

  cop0_exception_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .exc_valid        (exc_valid),
    .exc_code         (exc_code),
    .exc_epc          (exc_epc),
    .exc_bd           (exc_bd),
    .exc_has_badvaddr (exc_has_badvaddr),
    .exc_badvaddr     (exc_badvaddr),
    .eret_valid       (eret_valid),
    .busy             (busy),
    .done             (done),
    .handler_pc       (handler_pc),
    .cop0_we          (cop0_we),
    .cop0_write_rd    (cop0_write_rd),
    .cop0_write_sel   (cop0_write_sel),
    .cop0_din         (cop0_din),
    .cop0_read_rd     (cop0_read_rd),
    .cop0_read_sel    (cop0_read_sel),
    .cop0_rdata       (cop0_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CP0 register file model with a backdoor port for presetting registers.
  logic [31:0] mem [0:255];
  logic        pk_en = 1'b0;
  logic [7:0]  pk_addr = '0;
  logic [31:0] pk_data = '0;
  always @(posedge clk) begin
    if (cop0_we) mem[{cop0_write_rd, cop0_write_sel}] <= cop0_din;
    if (pk_en) mem[pk_addr] <= pk_data;
  end
  assign cop0_rdata = mem[{cop0_read_rd, cop0_read_sel}];

  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] pc; } dn_t;
  typedef struct { int cyc; logic busy; logic done; logic we; logic chk_pc; logic [31:0] pc; } snap_t;

  wr_t   wq[$];
  dn_t   dq[$];
  snap_t sq[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic fall_pending = 1'b0;
  logic end_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    if (fall_pending) begin
      check("busy_fall", {31'd0, busy}, 32'd0);
      fall_pending <= 1'b0;
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      check("snap_busy", {31'd0, busy}, {31'd0, sq[0].busy});
      check("snap_done", {31'd0, done}, {31'd0, sq[0].done});
      check("snap_we", {31'd0, cop0_we}, {31'd0, sq[0].we});
      if (sq[0].chk_pc) check("snap_handler_pc", handler_pc, sq[0].pc);
      void'(sq.pop_front());
    end
    if (cop0_we) begin
      if (wq.size() == 0) begin
        check("write_pending", 32'(wq.size()), 32'd1);
      end else begin
        check("write_addr", {24'd0, cop0_write_rd, cop0_write_sel}, {24'd0, wq[0].addr});
        check("write_data", cop0_din, wq[0].data);
        void'(wq.pop_front());
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        check("done_pending", 32'(dq.size()), 32'd1);
      end else begin
        check("done_cycle", 32'(cyc), 32'(dq[0].cyc));
        check("handler_pc", handler_pc, dq[0].pc);
        void'(dq.pop_front());
        fall_pending <= 1'b1;
      end
    end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
      check("done_timeout", 32'(cyc), 32'(dq[0].cyc));
      void'(dq.pop_front());
    end
    if (end_req) begin
      check("writes_drained", 32'(wq.size()), 32'd0);
      check("dones_drained", 32'(dq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    exc_valid        = 1'b0;
    eret_valid       = 1'b0;
    exc_code         = '0;
    exc_epc          = '0;
    exc_bd           = 1'b0;
    exc_has_badvaddr = 1'b0;
    exc_badvaddr     = '0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pk_addr = a;
    pk_data = d;
    pk_en   = 1'b1;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    wq.push_back('{a, d});
  endtask

  // Present a request in the current cycle, scramble inputs while busy, and return in the
  // cycle after done so the next request can be presented back to back.
  task automatic issue(input logic do_exc, input logic do_eret, input logic [4:0] code,
                       input logic [31:0] epc, input logic bd, input logic hb,
                       input logic [31:0] badv, input int lat, input logic [31:0] pc);
    int n;
    exc_valid        = do_exc;
    eret_valid       = do_eret;
    exc_code         = code;
    exc_epc          = epc;
    exc_bd           = bd;
    exc_has_badvaddr = hb;
    exc_badvaddr     = badv;
    n = cyc;
    dq.push_back('{n + lat, pc});
    sq.push_back('{n + 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(posedge clk);
    #1;
    exc_valid        = 1'b0;
    eret_valid       = 1'b1;
    exc_code         = ~code;
    exc_epc          = ~epc;
    exc_bd           = ~bd;
    exc_has_badvaddr = ~hb;
    exc_badvaddr     = ~badv;
    for (int i = 0; i < lat + 4; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk);
    #1 idle_inputs();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle_inputs();
    sq.push_back('{2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
    @(posedge clk);
    @(posedge clk);
    #1;
    poke(A_EBASE, 32'h8000_0ABC);
    poke(A_STATUS, 32'h0040_0004);
    poke(A_CAUSE, 32'h0000_0000);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // AdEL exception, full path.
    push_wr(A_EPC, 32'h0040_0010);
    push_wr(A_CAUSE, 32'h0000_0010);
    push_wr(A_BADV, 32'h1234_5679);
    push_wr(A_STATUS, 32'h0040_0006);
    issue(1'b1, 1'b0, 5'd4, 32'h0040_0010, 1'b0, 1'b1, 32'h1234_5679, 6 + XL, VEC_PC);

    // Delay-slot exception without BadVAddr.
    poke(A_STATUS, 32'h0040_0004);
    push_wr(A_EPC, 32'h0040_001C);
    push_wr(A_CAUSE, 32'h8000_0014);
    push_wr(A_STATUS, 32'h0040_0006);
    issue(1'b1, 1'b0, 5'd5, 32'h0040_0020, 1'b1, 1'b0, 32'h0, 5 + XL, VEC_PC);

    // Nested exception: EXL already set, BD preserved as 0.
    poke(A_CAUSE, 32'h0000_0000);
    push_wr(A_CAUSE, 32'h0000_0020);
    push_wr(A_STATUS, 32'h0040_0006);
    issue(1'b1, 1'b0, 5'd8, 32'h0040_0030, 1'b1, 1'b0, 32'h0, 4 + XL, VEC_PC);

    // Nested exception keeping BD = 1 and other Cause bits, with BadVAddr.
    poke(A_CAUSE, 32'h8000_FF7C);
    push_wr(A_CAUSE, 32'h8000_FF08);
    push_wr(A_BADV, 32'hDEAD_BEEF);
    push_wr(A_STATUS, 32'h0040_0006);
    issue(1'b1, 1'b0, 5'd2, 32'h0040_0040, 1'b0, 1'b1, 32'hDEAD_BEEF, 5 + XL, VEC_PC);

    // ERET, then a back-to-back request with both valids high (exception wins).
    poke(A_EPC, 32'h0040_0100);
    push_wr(A_STATUS, 32'h0040_0004);
    issue(1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 3, 32'h0040_0100);
    push_wr(A_EPC, 32'h0040_0200);
    push_wr(A_CAUSE, 32'h0000_FF30);
    push_wr(A_STATUS, 32'h0040_0006);
    issue(1'b1, 1'b1, 5'd12, 32'h0040_0200, 1'b0, 1'b0, 32'h0, 5 + XL, VEC_PC);

    // Abort: reset in the second busy cycle; nothing further may be written.
    exc_valid        = 1'b1;
    exc_code         = 5'd3;
    exc_epc          = 32'h0040_0300;
    exc_has_badvaddr = 1'b1;
    exc_badvaddr     = 32'h0000_0BAD;
    n = cyc;
    sq.push_back('{n + 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(posedge clk);
    #1 idle_inputs();
    @(posedge clk);
    #1 reset = 1'b1;
    sq.push_back('{n + 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    sq.push_back('{n + 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Recovery: ERET after the abort returns to the EPC written by the priority case.
    push_wr(A_STATUS, 32'h0040_0004);
    issue(1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 3, 32'h0040_0200);

    repeat (3) @(posedge clk);
    #1 end_req = 1'b1;
  end

endmodule
